// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the ID-stage hazard/stall controller.
//   reg_addr_t    : register address at the default architectural width
//   hazard_ctrl_t : the four pipeline-control enables, bundled so the decoder
//                   and the pipeline registers use one type
//   CTRL_*        : the four control words the controller can produce
package hazard_stall_controller_pkg;

  localparam int DFLT_REG_ADDR_W = 5;

  typedef logic [DFLT_REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic pc_write;
    logic fetch_write;
    logic make_bubble;
    logic flush_if_id;
  } hazard_ctrl_t;

  // Full pipeline hold: nothing advances, nothing is squashed.
  localparam hazard_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, fetch_write: 1'b0,
                                           make_bubble: 1'b0, flush_if_id: 1'b0};
  // Redirect: fetch the new target, squash IF/ID and the ID instruction.
  localparam hazard_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, fetch_write: 1'b1,
                                           make_bubble: 1'b1, flush_if_id: 1'b1};
  // Load-use stall: hold PC and IF/ID, send a bubble into EX.
  localparam hazard_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, fetch_write: 1'b0,
                                           make_bubble: 1'b1, flush_if_id: 1'b0};
  // Normal flow.
  localparam hazard_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, fetch_write: 1'b1,
                                           make_bubble: 1'b0, flush_if_id: 1'b0};

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle of the hazard controller's pipeline-side signals.
//   master : the pipeline side (drives EX/ID state, memory busy, branch, clear;
//            receives the enables and the stall counter)
//   slave  : the hazard controller
interface hazard_stall_controller_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);

  logic                  id_ex_mem_read;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  branch_taken;
  logic                  dmem_busy;
  logic                  cnt_clear;
  logic                  pc_write;
  logic                  fetch_write;
  logic                  make_bubble;
  logic                  flush_if_id;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output id_ex_mem_read, id_ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           branch_taken, dmem_busy, cnt_clear,
    input  pc_write, fetch_write, make_bubble, flush_if_id, stall_cycles
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           branch_taken, dmem_busy, cnt_clear,
    output pc_write, fetch_write, make_bubble, flush_if_id, stall_cycles
  );

endinterface

// File: rtl/hazard_stall_controller_load_scoreboard.sv
// Load-latency scoreboard: remembers loads that have left EX but whose data
// is not yet forwardable, and reports whether an ID source register depends
// on a pending load (either the load now in EX or a scoreboard entry).
//   clk, reset_n   : clock, asynchronous active-low reset
//   ex_load_i      : instruction in EX is a load
//   ex_rd_i        : destination of the instruction in EX
//   hold_i         : data memory busy, scoreboard holds
//   rs1_i, rs2_i   : ID source registers
//   match_rs1_o/2_o: source depends on a pending load
module hazard_stall_controller_load_scoreboard #(
  parameter int LOAD_LATENCY = 1,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ex_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  hold_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  match_rs1_o,
  output logic                  match_rs2_o
);

  localparam int DEPTH = LOAD_LATENCY - 1;

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 4) begin : g_bad_latency
    $error("LOAD_LATENCY must be in 1..4");
  end

  logic sb_hit_rs1;
  logic sb_hit_rs2;

  // x0 never creates a dependency, whatever the scoreboard holds.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] r,
                                     input logic                  ex_load,
                                     input logic [REG_ADDR_W-1:0] ex_rd,
                                     input logic                  sb_hit);
    return (r != '0) && ((ex_load && (ex_rd == r)) || sb_hit);
  endfunction

  if (DEPTH > 0) begin : g_sb
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [REG_ADDR_W-1:0] rd_q [DEPTH];
    logic [REG_ADDR_W-1:0] rd_d [DEPTH];

    always_comb begin
      vld_d = vld_q;
      rd_d  = rd_q;
      if (!hold_i) begin
        // A load to x0 enters as invalid so it can never match.
        vld_d[0] = ex_load_i && (ex_rd_i != '0);
        rd_d[0]  = ex_rd_i;
        for (int k = 1; k < DEPTH; k++) begin
          vld_d[k] = vld_q[k-1];
          rd_d[k]  = rd_q[k-1];
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
      end else begin
        vld_q <= vld_d;
        rd_q  <= rd_d;
      end
    end

    always_comb begin
      sb_hit_rs1 = 1'b0;
      sb_hit_rs2 = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (vld_q[k] && (rd_q[k] == rs1_i)) sb_hit_rs1 = 1'b1;
        if (vld_q[k] && (rd_q[k] == rs2_i)) sb_hit_rs2 = 1'b1;
      end
    end
  end else begin : g_no_sb
    // Single-cycle latency: only the load currently in EX can conflict.
    logic unused_sb_inputs;
    assign unused_sb_inputs = &{1'b0, clk, reset_n, hold_i};
    assign sb_hit_rs1 = 1'b0;
    assign sb_hit_rs2 = 1'b0;
  end

  assign match_rs1_o = reg_match(rs1_i, ex_load_i, ex_rd_i, sb_hit_rs1);
  assign match_rs2_o = reg_match(rs2_i, ex_load_i, ex_rd_i, sb_hit_rs2);

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard and stall controller. Produces PC / IF/ID / ID/EX control
// from the load-use check, data-memory freeze and taken-branch redirect, and
// counts load-use stall cycles in a saturating counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : EX/ID hazard inputs, dmem_busy, branch_taken, cnt_clear in;
//                  pc_write, fetch_write, make_bubble, flush_if_id,
//                  stall_cycles out
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  hazard_stall_controller_if.slave bus
);

  logic             match_rs1;
  logic             match_rs2;
  logic             load_use;
  hazard_ctrl_t     ctrl;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_stall_controller_load_scoreboard #(
    .LOAD_LATENCY (LOAD_LATENCY),
    .REG_ADDR_W   (REG_ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .ex_load_i   (bus.id_ex_mem_read),
    .ex_rd_i     (bus.id_ex_rd),
    .hold_i      (bus.dmem_busy),
    .rs1_i       (bus.id_rs1),
    .rs2_i       (bus.id_rs2),
    .match_rs1_o (match_rs1),
    .match_rs2_o (match_rs2)
  );

  // Unused sources must not stall: the field may hold arbitrary bits.
  assign load_use = (bus.id_uses_rs1 && match_rs1) ||
                    (bus.id_uses_rs2 && match_rs2);

  always_comb begin
    ctrl = CTRL_RUN;
    if (!reset_n) begin
      ctrl = CTRL_STALL;
    end else if (bus.dmem_busy) begin
      ctrl = CTRL_FREEZE;
    end else if (bus.branch_taken) begin
      // The ID instruction is squashed, so its load-use hazard is moot.
      ctrl = CTRL_FLUSH;
    end else if (load_use) begin
      ctrl = CTRL_STALL;
    end
  end

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.fetch_write = ctrl.fetch_write;
  assign bus.make_bubble = ctrl.make_bubble;
  assign bus.flush_if_id = ctrl.flush_if_id;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clear) begin
      cnt_d = '0;
    end else if (load_use && !bus.dmem_busy && !bus.branch_taken &&
                 (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;
  import hazard_stall_controller_pkg::*;

  logic      clk = 1'b0;
  logic      reset_n;
  logic      mem_read, uses1, uses2, br, busy, clr;
  reg_addr_t ex_rd, rs1, rs2;

  int n_tests = 0;
  int n_fail  = 0;

  // Control words as {pc_write, fetch_write, make_bubble, flush_if_id}.
  localparam logic [3:0] W_RUN    = 4'b1100;
  localparam logic [3:0] W_STALL  = 4'b0010;
  localparam logic [3:0] W_FREEZE = 4'b0000;
  localparam logic [3:0] W_FLUSH  = 4'b1111;
  localparam logic [3:0] W_RST    = 4'b0010;

  always #5 clk = ~clk;

  hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(16)) if1 ();
  hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(16)) if2 ();
  hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(16)) if3 ();
  hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(4))  if4 ();

  assign if1.id_ex_mem_read = mem_read; assign if2.id_ex_mem_read = mem_read;
  assign if3.id_ex_mem_read = mem_read; assign if4.id_ex_mem_read = mem_read;
  assign if1.id_ex_rd = ex_rd; assign if2.id_ex_rd = ex_rd;
  assign if3.id_ex_rd = ex_rd; assign if4.id_ex_rd = ex_rd;
  assign if1.id_rs1 = rs1; assign if2.id_rs1 = rs1;
  assign if3.id_rs1 = rs1; assign if4.id_rs1 = rs1;
  assign if1.id_rs2 = rs2; assign if2.id_rs2 = rs2;
  assign if3.id_rs2 = rs2; assign if4.id_rs2 = rs2;
  assign if1.id_uses_rs1 = uses1; assign if2.id_uses_rs1 = uses1;
  assign if3.id_uses_rs1 = uses1; assign if4.id_uses_rs1 = uses1;
  assign if1.id_uses_rs2 = uses2; assign if2.id_uses_rs2 = uses2;
  assign if3.id_uses_rs2 = uses2; assign if4.id_uses_rs2 = uses2;
  assign if1.branch_taken = br; assign if2.branch_taken = br;
  assign if3.branch_taken = br; assign if4.branch_taken = br;
  assign if1.dmem_busy = busy; assign if2.dmem_busy = busy;
  assign if3.dmem_busy = busy; assign if4.dmem_busy = busy;
  assign if1.cnt_clear = clr; assign if2.cnt_clear = clr;
  assign if3.cnt_clear = clr; assign if4.cnt_clear = clr;

  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(16))
    u_ll1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(2), .CNT_W(16))
    u_ll2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(16))
    u_ll3 (.clk(clk), .reset_n(reset_n), .bus(if3));
  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(4))
    u_c4 (.clk(clk), .reset_n(reset_n), .bus(if4));

  wire [3:0] c1 = {if1.pc_write, if1.fetch_write, if1.make_bubble, if1.flush_if_id};
  wire [3:0] c2 = {if2.pc_write, if2.fetch_write, if2.make_bubble, if2.flush_if_id};
  wire [3:0] c3 = {if3.pc_write, if3.fetch_write, if3.make_bubble, if3.flush_if_id};
  wire [3:0] c4 = {if4.pc_write, if4.fetch_write, if4.make_bubble, if4.flush_if_id};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mem_read = 1'b0; ex_rd = '0; rs1 = '0; rs2 = '0;
    uses1 = 1'b0; uses2 = 1'b0; br = 1'b0; busy = 1'b0; clr = 1'b0;
  endtask

  task automatic set_ex(input logic ld, input reg_addr_t rd);
    mem_read = ld; ex_rd = rd;
  endtask

  task automatic set_id(input reg_addr_t r1, input logic u1,
                        input reg_addr_t r2, input logic u2);
    rs1 = r1; uses1 = u1; rs2 = r2; uses2 = u2;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    set_ex(1'b1, 5'd5); set_id(5'd5, 1'b1, 5'd0, 1'b0);
    tick();
    n_tests++;
    if (c1 !== W_RST) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected %b", c1, W_RST);
    end
    n_tests++;
    if (if1.stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", if1.stall_cycles);
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (c1 !== W_STALL) begin
      n_fail++; $display("FAIL reset_release_stall: got %b expected %b", c1, W_STALL);
    end
  endtask

  task automatic test_ll1_load_use();
    do_reset();
    set_ex(1'b1, 5'd5); set_id(5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    n_tests++;
    if (c1 !== W_STALL) begin
      n_fail++; $display("FAIL ll1_stall: got %b expected %b", c1, W_STALL);
    end
    tick();
    set_ex(1'b0, 5'd0);
    #1;
    n_tests++;
    if (c1 !== W_RUN) begin
      n_fail++; $display("FAIL ll1_resume: got %b expected %b", c1, W_RUN);
    end
    n_tests++;
    if (if1.stall_cycles !== 16'd1) begin
      n_fail++; $display("FAIL ll1_cnt: got %0d expected 1", if1.stall_cycles);
    end
  endtask

  task automatic test_ll3_stall_length();
    // Consumer directly behind the load: three stall cycles.
    do_reset();
    set_ex(1'b1, 5'd7); set_id(5'd7, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (c3 !== W_STALL) begin
        n_fail++; $display("FAIL ll3_direct_stall%0d: got %b expected %b", i, c3, W_STALL);
      end
      tick();
      set_ex(1'b0, 5'd0);
    end
    #1;
    n_tests++;
    if (c3 !== W_RUN) begin
      n_fail++; $display("FAIL ll3_direct_resume: got %b expected %b", c3, W_RUN);
    end
    n_tests++;
    if (if3.stall_cycles !== 16'd3) begin
      n_fail++; $display("FAIL ll3_direct_cnt: got %0d expected 3", if3.stall_cycles);
    end
    // Consumer one slot later: two stall cycles.
    do_reset();
    set_ex(1'b1, 5'd7); set_id(5'd1, 1'b1, 5'd0, 1'b0);
    #1;
    n_tests++;
    if (c3 !== W_RUN) begin
      n_fail++; $display("FAIL ll3_slot_indep: got %b expected %b", c3, W_RUN);
    end
    tick();
    set_ex(1'b0, 5'd1); set_id(5'd7, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (c3 !== W_STALL) begin
        n_fail++; $display("FAIL ll3_slot_stall%0d: got %b expected %b", i, c3, W_STALL);
      end
      tick();
      set_ex(1'b0, 5'd0);
    end
    #1;
    n_tests++;
    if (c3 !== W_RUN) begin
      n_fail++; $display("FAIL ll3_slot_resume: got %b expected %b", c3, W_RUN);
    end
    n_tests++;
    if (if3.stall_cycles !== 16'd2) begin
      n_fail++; $display("FAIL ll3_slot_cnt: got %0d expected 2", if3.stall_cycles);
    end
  endtask

  task automatic test_no_false_stall();
    do_reset();
    set_ex(1'b1, 5'd0); set_id(5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    n_tests++;
    if (c1 !== W_RUN || c3 !== W_RUN) begin
      n_fail++; $display("FAIL x0_load: got %b/%b expected %b", c1, c3, W_RUN);
    end
    tick();
    set_ex(1'b1, 5'd5); set_id(5'd3, 1'b1, 5'd5, 1'b0);
    #1;
    n_tests++;
    if (c1 !== W_RUN || c3 !== W_RUN) begin
      n_fail++; $display("FAIL unused_rs2: got %b/%b expected %b", c1, c3, W_RUN);
    end
    tick();
    set_idle();
    #1;
    n_tests++;
    if (if1.stall_cycles !== 16'd0 || if3.stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL nostall_cnt: got %0d/%0d expected 0",
                         if1.stall_cycles, if3.stall_cycles);
    end
  endtask

  task automatic test_branch_override();
    do_reset();
    set_ex(1'b1, 5'd5); set_id(5'd5, 1'b1, 5'd0, 1'b0); br = 1'b1;
    #1;
    n_tests++;
    if (c1 !== W_FLUSH) begin
      n_fail++; $display("FAIL branch_ctrl: got %b expected %b", c1, W_FLUSH);
    end
    tick();
    set_idle();
    #1;
    n_tests++;
    if (if1.stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL branch_cnt: got %0d expected 0", if1.stall_cycles);
    end
  endtask

  task automatic test_dmem_freeze();
    do_reset();
    set_ex(1'b1, 5'd9); set_id(5'd9, 1'b1, 5'd0, 1'b0);
    #1;
    n_tests++;
    if (c2 !== W_STALL) begin
      n_fail++; $display("FAIL ll2_first: got %b expected %b", c2, W_STALL);
    end
    tick();
    set_ex(1'b0, 5'd0); busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (c2 !== W_FREEZE) begin
        n_fail++; $display("FAIL freeze%0d: got %b expected %b", i, c2, W_FREEZE);
      end
      tick();
    end
    busy = 1'b0;
    #1;
    n_tests++;
    if (c2 !== W_STALL) begin
      n_fail++; $display("FAIL freeze_release_stall: got %b expected %b", c2, W_STALL);
    end
    tick();
    #1;
    n_tests++;
    if (c2 !== W_RUN) begin
      n_fail++; $display("FAIL freeze_resume: got %b expected %b", c2, W_RUN);
    end
    n_tests++;
    if (if2.stall_cycles !== 16'd2) begin
      n_fail++; $display("FAIL freeze_cnt: got %0d expected 2", if2.stall_cycles);
    end
  endtask

  task automatic test_both_sources();
    do_reset();
    set_ex(1'b1, 5'd7); set_id(5'd1, 1'b1, 5'd0, 1'b0);
    tick();
    set_ex(1'b1, 5'd8); set_id(5'd7, 1'b1, 5'd8, 1'b1);
    #1;
    n_tests++;
    if (c3 !== W_STALL) begin
      n_fail++; $display("FAIL both_src_stall: got %b expected %b", c3, W_STALL);
    end
    tick();
    set_ex(1'b0, 5'd0);
    #1;
    n_tests++;
    if (if3.stall_cycles !== 16'd1) begin
      n_fail++; $display("FAIL both_src_cnt: got %0d expected 1", if3.stall_cycles);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_ex(1'b1, 5'd5); set_id(5'd5, 1'b1, 5'd0, 1'b0);
    repeat (20) tick();
    n_tests++;
    if (if4.stall_cycles !== 4'd15) begin
      n_fail++; $display("FAIL sat_cnt: got %0d expected 15", if4.stall_cycles);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    n_tests++;
    if (if4.stall_cycles !== 4'd0) begin
      n_fail++; $display("FAIL clear_cnt: got %0d expected 0", if4.stall_cycles);
    end
    tick();
    n_tests++;
    if (if4.stall_cycles !== 4'd1) begin
      n_fail++; $display("FAIL after_clear_cnt: got %0d expected 1", if4.stall_cycles);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_ex(1'b1, 5'd7); set_id(5'd7, 1'b1, 5'd0, 1'b0);
    tick();
    set_ex(1'b0, 5'd0);
    #1;
    n_tests++;
    if (c3 !== W_STALL) begin
      n_fail++; $display("FAIL mid_stall_pre: got %b expected %b", c3, W_STALL);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (c3 !== W_RST || if3.stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL mid_stall_reset: got %b cnt %0d expected %b cnt 0",
                         c3, if3.stall_cycles, W_RST);
    end
    #2;
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (c3 !== W_RUN) begin
      n_fail++; $display("FAIL mid_stall_empty: got %b expected %b", c3, W_RUN);
    end
    tick();
    n_tests++;
    if (c3 !== W_RUN) begin
      n_fail++; $display("FAIL mid_stall_empty2: got %b expected %b", c3, W_RUN);
    end
  endtask

  initial begin
    set_idle();
    reset_n = 1'b0;
    test_reset();
    test_ll1_load_use();
    test_ll3_stall_length();
    test_no_false_stall();
    test_branch_override();
    test_dmem_freeze();
    test_both_sources();
    test_saturation();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Parametrised successor to the single-cycle load-use detector. Sits in the ID stage and drives the PC, IF/ID and ID/EX control.
- Adds a load-latency scoreboard for loads whose data arrives more than one cycle after EX.
- Suppresses false stalls for unused source operands and for x0.
- Adds an external data-memory freeze, a taken-branch flush, and a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register address width.
- LOAD_LATENCY, 1, cycles after a load leaves EX before its data is forwardable. 1 gives the classic one-bubble load-use stall. Legal range 1..4.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID.
- id_uses_rs1  in  1  instruction in ID reads rs1.
- id_uses_rs2  in  1  instruction in ID reads rs2.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- dmem_busy  in  1  data memory not ready; whole pipeline must hold.
- cnt_clear  in  1  synchronous clear of stall_cycles.
- pc_write  out  1  PC update enable.
- fetch_write  out  1  IF/ID register enable.
- make_bubble  out  1  zero the control word entering ID/EX.
- flush_if_id  out  1  invalidate IF/ID contents.
- stall_cycles  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset: async clear of every scoreboard entry and of stall_cycles.
- While reset_n is low, outputs are forced: pc_write=0, fetch_write=0, make_bubble=1, flush_if_id=0, stall_cycles=0.
- Scoreboard: shift register of LOAD_LATENCY-1 entries, each {valid, rd}. It is empty when LOAD_LATENCY=1.
  - Entry 0 is loaded with {id_ex_mem_read && id_ex_rd!=0, id_ex_rd} on every cycle where dmem_busy=0.
  - Entry k+1 takes entry k on the same condition.
  - When dmem_busy=1, all entries hold.
- Match(r): r!=0 and either (id_ex_mem_read and id_ex_rd==r) or some valid scoreboard entry has rd==r.
- load_use = (id_uses_rs1 and Match(id_rs1)) or (id_uses_rs2 and Match(id_rs2)).
- Outputs are combinational from inputs and scoreboard state, with no added latency. Priority is highest first:
  1. dmem_busy=1: pc_write=0, fetch_write=0, make_bubble=0, flush_if_id=0. Full freeze.
  2. branch_taken=1: pc_write=1, fetch_write=1, make_bubble=1, flush_if_id=1. Redirect overrides any load-use stall, because the ID instruction is squashed.
  3. load_use=1: pc_write=0, fetch_write=0, make_bubble=1, flush_if_id=0.
  4. Otherwise: pc_write=1, fetch_write=1, make_bubble=0, flush_if_id=0.
- Stall length: a consumer directly behind a load stalls for exactly LOAD_LATENCY cycles. A consumer two instructions behind stalls for LOAD_LATENCY-1 cycles.
- Counter:
  - Increments by 1 on each clock edge where priority-3 holds with dmem_busy=0 and branch_taken=0.
  - Saturates at 2^CNT_W-1.
  - cnt_clear takes priority over increment and sets the counter to 0 on the next edge.
- Boundaries:
  - A load with rd=0 never stalls and never enters the scoreboard as valid.
  - Both sources matching different pending loads is still a single stall condition.
  - Deassertion of reset mid-stall resumes with an empty scoreboard.

Decomposition:
- common package gains reg_addr_t (logic [REG_ADDR_W-1:0]).
- common package gains a hazard_ctrl_t struct {pc_write, fetch_write, make_bubble, flush_if_id} so the decoder and pipeline registers share one type.
- Sub-module load_scoreboard: the shift register plus the per-register match function, with LOAD_LATENCY and REG_ADDR_W parameters.

Test Plan:
- LOAD_LATENCY=1: load x5 in EX, ID add reads rs1=x5 with use=1 -> one cycle pc_write=0, fetch_write=0, make_bubble=1. Next cycle all clear; stall_cycles=1.
- LOAD_LATENCY=3: load x7, then dependent instruction directly behind -> exactly 3 stall cycles, stall_cycles=3. Dependent instruction one slot later -> 2 stall cycles.
- Load x0, then reader of x0; and load x5, then instruction with rs2=x5 but id_uses_rs2=0 -> no stall, counter unchanged.
- Load-use active and branch_taken=1 in the same cycle -> flush_if_id=1, make_bubble=1, pc_write=1; counter not incremented.
- LOAD_LATENCY=2: dmem_busy=1 for 4 cycles while load x9 is pending -> all enables 0, make_bubble=0, scoreboard held. After release, the dependent instruction still stalls the remaining cycles.
- CNT_W=4: force 20 stall cycles -> stall_cycles saturates at 15; cnt_clear for one cycle -> 0. Assert reset_n=0 mid-stall -> outputs at reset values; scoreboard empty after release.
